dmem_ctrl: RTL

Data-memory access controller that sits directly downstream of the single-cycle CPU datapath, taking the place of the ideal one-cycle data memory. It accepts the load/store request driven by the decoder's MemRead/MemWrite and the ALU address, runs a req/ack handshake to a variable-latency memory, and raises a stall that freezes the PC and the register-file write until the access completes. It also flags misaligned word accesses.

---
 rtl/dmem_ctrl_pkg.sv | 20 ++
 rtl/dmem_wbuf.sv | 54 +++++
 rtl/dmem_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings and defaults for the data-memory access controller.
package dmem_ctrl_pkg;

  localparam int unsigned ADDR_W_DFLT = 32;
  localparam int unsigned DATA_W_DFLT = 32;

  // Byte-offset bits that must be zero for a word access.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return (byte_off & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// One-entry posted write buffer for dmem_ctrl; only compiled in when
// DMEM_CTRL_WBUF_EN is defined, so the default build carries no unused module.
`ifdef DMEM_CTRL_WBUF_EN
module dmem_wbuf #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              ack_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (push_i) begin
      valid_d = 1'b1;
      addr_d  = push_addr_i;
      data_d  = push_data_i;
    end else if (ack_i && valid_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // The drain request is simply "entry present".
  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule
`endif

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: CPU load/store to req/ack memory with stall.
// Define DMEM_CTRL_WBUF_EN to add a one-entry posted write buffer.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DFLT,
  parameter int unsigned DATA_W = DATA_W_DFLT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  input  logic              m_ack_i,
  input  logic [DATA_W-1:0] m_rdata_i
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(ALIGN_MASK);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              we_q, we_d;
  logic              misalign_q, misalign_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] rdata_c;
  logic              stall_c, req_c;
  logic              access, misal;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

`ifdef DMEM_CTRL_WBUF_EN
  logic wb_push, wb_ack;

  assign wb_ack = wb_valid & m_ack_i;

  dmem_wbuf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_wbuf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (wb_push),
    .push_addr_i (addr_i & WORD_MASK),
    .push_data_i (wdata_i),
    .ack_i       (wb_ack),
    .valid_o     (wb_valid),
    .addr_o      (wb_addr),
    .data_o      (wb_data)
  );
`else
  assign wb_valid = 1'b0;
  assign wb_addr  = '0;
  assign wb_data  = '0;
`endif

  assign access = mem_read_i | mem_write_i;
  assign misal  = access & is_misaligned(addr_i[1:0]);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    err_addr_d = err_addr_q;
    stall_c    = 1'b0;
    req_c      = 1'b0;
    rdata_c    = '0;
`ifdef DMEM_CTRL_WBUF_EN
    wb_push    = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (misal) begin
          misalign_d = 1'b1;
          if (!misalign_q) err_addr_d = addr_i;
        end else if (access) begin
`ifdef DMEM_CTRL_WBUF_EN
          // Buffer owns the port while full: every access waits for the drain.
          if (wb_valid) begin
            stall_c = 1'b1;
          end else if (mem_write_i) begin
            wb_push = 1'b1;
          end else begin
            stall_c = 1'b1;
            addr_d  = addr_i & WORD_MASK;
            we_d    = 1'b0;
            wdata_d = wdata_i;
            rdata_d = '0;
            state_d = ST_REQ;
          end
`else
          stall_c = 1'b1;
          addr_d  = addr_i & WORD_MASK;
          we_d    = mem_write_i;
          wdata_d = wdata_i;
          rdata_d = '0;
          state_d = ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (m_ack_i) begin
          rdata_d = we_q ? '0 : m_rdata_i;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        rdata_c = rdata_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign stall_o    = rst_i & stall_c;
  assign m_req_o    = rst_i & (req_c | wb_valid);
  assign m_we_o     = wb_valid ? 1'b1 : we_q;
  assign m_addr_o   = wb_valid ? wb_addr : addr_q;
  assign m_wdata_o  = wb_valid ? wb_data : wdata_q;
  assign rdata_o    = rst_i ? rdata_c : '0;
  assign misalign_o = misalign_q;
  assign err_addr_o = err_addr_q;

endmodule
